// File: rtl/ddr2_rd_data_reader_0_if.sv
// Capture-RAM read-side bundle for ddr2_rd_data_reader_0.
// Handshake: rd_burst_req is a single-cycle pulse with no back-pressure. rd_data is qualified only by rd_data_valid (no ready).
interface ddr2_rd_data_reader_0_if #(
  parameter int DATA_WIDTH = 16
);
  logic [3:0]            wr_ptr;
  logic                  rd_burst_req;
  logic [DATA_WIDTH-1:0] dpo;
  logic [3:0]            dpra;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  rd_burst_done;
  logic [2:0]            pending;
  logic                  req_overflow_err;
  logic                  state_dbg;

  modport master (
    input  wr_ptr, rd_burst_req, dpo,
    output dpra, rd_data, rd_data_valid, rd_burst_done, pending,
           req_overflow_err, state_dbg
  );

  modport slave (
    output wr_ptr, rd_burst_req, dpo,
    input  dpra, rd_data, rd_data_valid, rd_burst_done, pending,
           req_overflow_err, state_dbg
  );
endinterface

// File: rtl/ddr2_rd_data_reader_0.sv
// Drains the DDR2 read-capture RAM one word per cycle for each requested burst.
// It keeps track of the outstanding bursts. BURST_LEN may only be 4 or 8.
module ddr2_rd_data_reader_0 #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                      clk0,
  input  logic                      rst0_n,
  ddr2_rd_data_reader_0_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [2:0] LAST_BEAT    = 3'(BURST_LEN - 1);
  localparam logic [2:0] PENDING_FULL = 3'd4;

  state_t                state_q, state_d;
  logic [3:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            beat_cnt_q, beat_cnt_d;
  logic [2:0]            pending_q, pending_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic available;
  logic beat;
  logic last_beat;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      pending_q  <= '0;
      rd_data_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    pending_d  = pending_q;
    rd_data_d  = rd_data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    state_d    = state_q;

    available = (bus.wr_ptr != rd_ptr_q);
    beat      = (state_q == READ) && available;
    last_beat = beat && (beat_cnt_q == LAST_BEAT);

    if (beat) begin
      rd_data_d  = bus.dpo;
      valid_d    = 1'b1;
      rd_ptr_d   = rd_ptr_q + 4'd1;
      beat_cnt_d = last_beat ? 3'd0 : beat_cnt_q + 3'd1;
      done_d     = last_beat;
    end

    // A new request arriving in the same cycle as a completion cancels the decrement.
    unique case ({bus.rd_burst_req, last_beat})
      2'b01: pending_d = pending_q - 3'd1;
      2'b10: begin
        if (pending_q == PENDING_FULL) ovf_d = 1'b1;
        else                           pending_d = pending_q + 3'd1;
      end
      default: pending_d = pending_q;
    endcase

    unique case (state_q)
      IDLE:    if (pending_d != 3'd0) state_d = READ;
      READ:    if (pending_d == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.dpra             = rd_ptr_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.rd_data_valid    = valid_q;
  assign bus.rd_burst_done    = done_q;
  assign bus.pending          = pending_q;
  assign bus.req_overflow_err = ovf_q;
  assign bus.state_dbg        = state_q;

endmodule
